// File: rtl/move_exec_arbiter_pkg.sv
// Shared chess types (board, move, special codes) plus the move-executor arbiter state.
package move_exec_arbiter_pkg;

  typedef logic [63:0][3:0] board_t;

  typedef enum logic [2:0] {
    SPECIAL_NONE      = 3'd0,
    SPECIAL_CASTLE    = 3'd1,
    SPECIAL_ENPASSANT = 3'd2,
    SPECIAL_PROMO_Q   = 3'd3,
    SPECIAL_PROMO_R   = 3'd4,
    SPECIAL_PROMO_B   = 3'd5,
    SPECIAL_PROMO_N   = 3'd6
  } special_t;

  typedef struct packed {
    logic [2:0] src_col;
    logic [2:0] src_row;
    logic [2:0] dst_col;
    logic [2:0] dst_row;
    special_t   special;
  } move_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_t;

  localparam int ARB_NUM_REQ = 2;

  function automatic logic [ARB_NUM_REQ-1:0] arb_onehot(input logic idx);
    arb_onehot = idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/move_exec_arbiter_grant.sv
// Combinational grant for the two move-executor requesters.
// MOVE_ARB_ROUND_ROBIN_EN: ties go to the requester that did not own the last job.
module move_arb_grant
  import move_exec_arbiter_pkg::*;
(
  input  logic [ARB_NUM_REQ-1:0] i_valid,
`ifdef MOVE_ARB_ROUND_ROBIN_EN
  input  logic                   i_last_owner,
`endif
  output logic [ARB_NUM_REQ-1:0] o_grant
);

  // One-hot grant from the offered valids
  always_comb begin
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
`ifdef MOVE_ARB_ROUND_ROBIN_EN
      2'b11:   o_grant = i_last_owner ? 2'b01 : 2'b10;
`else
      2'b11:   o_grant = 2'b01;
`endif
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/move_exec_arbiter.sv
// Shares one move_executor between the UCI path (req0) and the search path (req1), with a hang watchdog.
// Build option: MOVE_ARB_ROUND_ROBIN_EN (round-robin tie-break; default is fixed req0 priority).
module move_exec_arbiter
  import move_exec_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  board_t     req0_board_in,
  input  move_t      req0_move_in,
  input  logic       req0_valid_in,
  output logic       req0_ready_out,
  output board_t     req0_board_out,
  output logic       req0_valid_out,
  input  board_t     req1_board_in,
  input  move_t      req1_move_in,
  input  logic       req1_valid_in,
  output logic       req1_ready_out,
  output board_t     req1_board_out,
  output logic       req1_valid_out,
  output logic [1:0] req_err_out,
  output board_t     exec_board_out,
  output move_t      exec_move_out,
  output logic       exec_valid_out,
  input  board_t     exec_board_in,
  input  logic       exec_valid_in,
  output logic       busy_out
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arb_state_t             r_state;
  arb_state_t             w_next;
  logic                   r_owner;
  logic [CNT_W-1:0]       r_cnt;
  board_t                 r_exec_board;
  move_t                  r_exec_move;
  logic                   r_exec_valid;
  board_t                 r_req0_board;
  board_t                 r_req1_board;
  logic                   r_req0_valid;
  logic                   r_req1_valid;
  logic [ARB_NUM_REQ-1:0] r_err;
  logic [ARB_NUM_REQ-1:0] w_valid;
  logic [ARB_NUM_REQ-1:0] w_grant;
  logic                   w_accept;
  logic                   w_timeout;
`ifdef MOVE_ARB_ROUND_ROBIN_EN
  logic                   r_last_owner;
`endif

  assign w_valid = {req1_valid_in, req0_valid_in};

  move_arb_grant u_grant (
    .i_valid      (w_valid),
`ifdef MOVE_ARB_ROUND_ROBIN_EN
    .i_last_owner (r_last_owner),
`endif
    .o_grant      (w_grant)
  );

  // Grant is a subset of valid, so any grant in IDLE is a transfer
  assign w_accept  = (r_state == ARB_IDLE) && (w_grant != 2'b00);
  assign w_timeout = (r_state == ARB_WAIT) && !exec_valid_in && (r_cnt == CNT_LAST);

  // State and datapath registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state      <= ARB_IDLE;
      r_owner      <= 1'b0;
      r_cnt        <= '0;
      r_exec_board <= '0;
      r_exec_move  <= '0;
      r_exec_valid <= 1'b0;
      r_req0_board <= '0;
      r_req1_board <= '0;
      r_req0_valid <= 1'b0;
      r_req1_valid <= 1'b0;
      r_err        <= 2'b00;
`ifdef MOVE_ARB_ROUND_ROBIN_EN
      r_last_owner <= 1'b1;
`endif
    end else begin
      r_state      <= w_next;
      r_exec_valid <= 1'b0;
      r_req0_valid <= 1'b0;
      r_req1_valid <= 1'b0;
      r_err        <= 2'b00;
      case (r_state)
        ARB_IDLE: begin
          if (w_accept) begin
            r_owner      <= w_grant[1];
            r_exec_board <= w_grant[1] ? req1_board_in : req0_board_in;
            r_exec_move  <= w_grant[1] ? req1_move_in : req0_move_in;
`ifdef MOVE_ARB_ROUND_ROBIN_EN
            r_last_owner <= w_grant[1];
`endif
          end
        end
        ARB_ISSUE: begin
          r_exec_valid <= 1'b1;
          r_cnt        <= '0;
        end
        ARB_WAIT: begin
          if (exec_valid_in) begin
            if (r_owner) begin
              r_req1_board <= exec_board_in;
              r_req1_valid <= 1'b1;
            end else begin
              r_req0_board <= exec_board_in;
              r_req0_valid <= 1'b1;
            end
          end else if (w_timeout) begin
            r_err <= arb_onehot(r_owner);
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (w_accept) w_next = ARB_ISSUE;
        else          w_next = ARB_IDLE;
      end
      ARB_ISSUE: w_next = ARB_WAIT;
      ARB_WAIT: begin
        if (exec_valid_in || w_timeout) w_next = ARB_IDLE;
        else                            w_next = ARB_WAIT;
      end
      default: w_next = ARB_IDLE;
    endcase
  end

  // Handshake and status outputs
  always_comb begin
    req0_ready_out = (r_state == ARB_IDLE) && w_grant[0];
    req1_ready_out = (r_state == ARB_IDLE) && w_grant[1];
    busy_out       = (r_state != ARB_IDLE);
  end

  assign exec_board_out = r_exec_board;
  assign exec_move_out  = r_exec_move;
  assign exec_valid_out = r_exec_valid;
  assign req0_board_out = r_req0_board;
  assign req1_board_out = r_req1_board;
  assign req0_valid_out = r_req0_valid;
  assign req1_valid_out = r_req1_valid;
  assign req_err_out    = r_err;

endmodule

// File: tb/tb_move_exec_arbiter.sv
// Scoreboard bench for move_exec_arbiter: a TIMEOUT_CYCLES=8 instance for most cases and a
// TIMEOUT_CYCLES=4 instance for the result-at-threshold case. Honours MOVE_ARB_ROUND_ROBIN_EN.
module tb_move_exec_arbiter;
  import move_exec_arbiter_pkg::*;

  localparam int TMO = 8;

  typedef struct {
    logic   owner;
    logic   is_err;
    board_t board;
    int     due;
  } exp_t;

  logic   clk, rst;
  board_t r0b, r1b, r0bo, r1bo, ebo, ebi, inj_b;
  move_t  r0m, r1m, emo;
  logic   r0v, r1v, r0rdy, r1rdy, r0vo, r1vo, evo, evi, busy, inj_v, hang;
  logic [1:0] err;
  int     lat;

  board_t t4_r0b, t4_r1b, t4_r0bo, t4_r1bo, t4_ebo, t4_ebi;
  move_t  t4_r0m, t4_r1m, t4_emo;
  logic   t4_r0v, t4_r1v, t4_r0rdy, t4_r1rdy, t4_r0vo, t4_r1vo, t4_evo, t4_evi, t4_busy;
  logic [1:0] t4_err;

  exp_t   q[$];
  int     grant_log[$];
  int     n_cmp, n_mis, cyc, n_pulse, last_acc;
  int     acc_edge [2];
  move_t  last_move;
  board_t last_board;
  int     t4_acc, t4_res_n, t4_res_cyc, t4_err_n;
  board_t t4_res_board;
  int     exp_order [4];

  move_exec_arbiter #(.TIMEOUT_CYCLES(TMO)) u_dut (
    .clk_in(clk), .rst_in(rst),
    .req0_board_in(r0b), .req0_move_in(r0m), .req0_valid_in(r0v), .req0_ready_out(r0rdy),
    .req0_board_out(r0bo), .req0_valid_out(r0vo),
    .req1_board_in(r1b), .req1_move_in(r1m), .req1_valid_in(r1v), .req1_ready_out(r1rdy),
    .req1_board_out(r1bo), .req1_valid_out(r1vo),
    .req_err_out(err), .exec_board_out(ebo), .exec_move_out(emo), .exec_valid_out(evo),
    .exec_board_in(ebi), .exec_valid_in(evi), .busy_out(busy)
  );

  move_exec_arbiter #(.TIMEOUT_CYCLES(4)) u_dut4 (
    .clk_in(clk), .rst_in(rst),
    .req0_board_in(t4_r0b), .req0_move_in(t4_r0m), .req0_valid_in(t4_r0v), .req0_ready_out(t4_r0rdy),
    .req0_board_out(t4_r0bo), .req0_valid_out(t4_r0vo),
    .req1_board_in(t4_r1b), .req1_move_in(t4_r1m), .req1_valid_in(t4_r1v), .req1_ready_out(t4_r1rdy),
    .req1_board_out(t4_r1bo), .req1_valid_out(t4_r1vo),
    .req_err_out(t4_err), .exec_board_out(t4_ebo), .exec_move_out(t4_emo), .exec_valid_out(t4_evo),
    .exec_board_in(t4_ebi), .exec_valid_in(t4_evi), .busy_out(t4_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic board_t start_board();
    board_t b;
    logic [31:0] br;
    b  = '0;
    br = 32'h42365324;
    for (int c = 0; c < 8; c++) begin
      b[c]      = br[4*c +: 4];
      b[8 + c]  = 4'd1;
      b[48 + c] = 4'd9;
      b[56 + c] = br[4*c +: 4] | 4'b1000;
    end
    return b;
  endfunction

  function automatic board_t apply_move(input board_t b, input move_t m);
    board_t r;
    int s, d;
    r = b;
    s = int'(m.src_row) * 8 + int'(m.src_col);
    d = int'(m.dst_row) * 8 + int'(m.dst_col);
    r[d] = b[s];
    r[s] = 4'd0;
    return r;
  endfunction

  function automatic move_t mk(input int sc, input int sr, input int dc, input int dr);
    move_t m;
    m.src_col = 3'(sc);
    m.src_row = 3'(sr);
    m.dst_col = 3'(dc);
    m.dst_row = 3'(dr);
    m.special = SPECIAL_NONE;
    return m;
  endfunction

  // Executor models: a pure register pipeline of variable depth, optionally hung
  logic [7:0] pv = 8'd0;
  board_t     pb [8];
  always @(posedge clk) begin
    pv    <= {pv[6:0], evo && !hang};
    pb[0] <= apply_move(ebo, emo);
    for (int k = 1; k < 8; k++) pb[k] <= pb[k-1];
  end
  assign evi = pv[lat-1] | inj_v;
  assign ebi = inj_v ? inj_b : pb[lat-1];

  logic [2:0] t4_pv = 3'd0;
  board_t     t4_pb [3];
  always @(posedge clk) begin
    t4_pv    <= {t4_pv[1:0], t4_evo};
    t4_pb[0] <= apply_move(t4_ebo, t4_emo);
    t4_pb[1] <= t4_pb[0];
    t4_pb[2] <= t4_pb[1];
  end
  assign t4_evi = t4_pv[2];
  assign t4_ebi = t4_pb[2];

  task automatic check_value(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_job(input logic owner, input board_t b, input move_t m);
    exp_t e;
    e.owner  = owner;
    e.is_err = hang;
    e.board  = apply_move(b, m);
    e.due    = hang ? cyc + 2 + TMO : cyc + 1 + lat + 2;
    q.push_back(e);
    grant_log.push_back(owner ? 1 : 0);
    last_acc        = cyc + 1;
    acc_edge[owner] = cyc + 1;
    last_move       = m;
    last_board      = b;
  endtask

  task automatic sample();
    exp_t e;
    logic [1:0] oh;
    if (rst) return;
    if (busy) check_value("ready_busy", {r1rdy, r0rdy}, 0);
    if (r0vo || r1vo || err != 2'b00) begin
      n_pulse++;
      if (q.size() == 0) begin
        check_value("unexpected_pulse", {err, r1vo, r0vo}, 0);
      end else begin
        e  = q.pop_front();
        oh = e.owner ? 2'b10 : 2'b01;
        check_value("route", {err, r1vo, r0vo}, e.is_err ? {oh, 2'b00} : {2'b00, oh});
        check_value("latency", cyc, e.due);
        if (!e.is_err) check_value("board", e.owner ? r1bo : r0bo, e.board);
      end
    end else if (q.size() != 0 && q[0].due < cyc) begin
      check_value("missing_result", cyc, q[0].due);
      void'(q.pop_front());
    end
    if (r0v && r0rdy) push_job(1'b0, r0b, r0m);
    if (r1v && r1rdy) push_job(1'b1, r1b, r1m);
    if (evo) begin
      check_value("issue_lat", cyc - last_acc, 1);
      check_value("issue_move", emo, last_move);
      check_value("issue_board", ebo, last_board);
    end
    if (t4_r0v && t4_r0rdy) t4_acc = cyc + 1;
    if (t4_r0vo) begin
      t4_res_n++;
      t4_res_cyc   = cyc;
      t4_res_board = t4_r0bo;
    end
    if (t4_err != 2'b00) t4_err_n++;
    if (t4_r1vo) check_value("t4_req1_pulse", t4_r1vo, 0);
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic offer(input logic idx, input board_t b, input move_t m);
    int gs;
    gs = grant_log.size();
    if (idx) begin r1b = b; r1m = m; r1v = 1'b1; end
    else     begin r0b = b; r0m = m; r0v = 1'b1; end
    for (int t = 0; t < 50 && grant_log.size() == gs; t++) tick();
    r0v = 1'b0;
    r1v = 1'b0;
    check_value("offer_accept", grant_log.size() - gs, 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && q.size() != 0; t++) tick();
    check_value("drain_empty", q.size(), 0);
    repeat (3) tick();
  endtask

  initial begin
    int g0, gs, n0, n1, np;
`ifdef MOVE_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    n_cmp = 0; n_mis = 0; cyc = 0; n_pulse = 0; last_acc = 0;
    acc_edge[0] = 0; acc_edge[1] = 0;
    t4_acc = 0; t4_res_n = 0; t4_res_cyc = 0; t4_err_n = 0; t4_res_board = '0;
    last_move = '0; last_board = '0;
    rst = 1'b1; hang = 1'b0; lat = 3; inj_v = 1'b0; inj_b = '0;
    r0b = '0; r0m = '0; r0v = 1'b0; r1b = '0; r1m = '0; r1v = 1'b0;
    t4_r0b = '0; t4_r0m = '0; t4_r0v = 1'b0; t4_r1b = '0; t4_r1m = '0; t4_r1v = 1'b0;
    repeat (3) tick();

    check_value("rst_busy", busy, 0);
    check_value("rst_pulses", {err, r1vo, r0vo, evo}, 0);
    check_value("rst_exec_board", ebo, 0);
    check_value("rst_exec_move", emo, 0);
    check_value("rst_req0_board", r0bo, 0);
    check_value("rst_req1_board", r1bo, 0);
    check_value("rst_t4_busy", t4_busy, 0);
    rst = 1'b0;

    // Both requesters held valid for four jobs
    n0 = 0; n1 = 0;
    r0b = start_board(); r0m = mk(0, 1, 0, 2);
    r1b = apply_move(start_board(), mk(4, 1, 4, 3)); r1m = mk(0, 6, 0, 5);
    r0v = 1'b1; r1v = 1'b1;
    g0 = grant_log.size();
    for (int t = 0; t < 100 && grant_log.size() - g0 < 4; t++) begin
      gs = grant_log.size();
      tick();
      if (grant_log.size() != gs) begin
        if (grant_log[gs] == 0) begin n0++; r0m = mk(n0, 1, n0, 2); end
        else                    begin n1++; r1m = mk(n1, 6, n1, 5); end
        if (grant_log.size() - g0 == 4) begin r0v = 1'b0; r1v = 1'b0; end
      end
    end
    r0v = 1'b0; r1v = 1'b0;
    check_value("grant_count", grant_log.size() - g0, 4);
    for (int k = 0; k < 4; k++)
      if (g0 + k < grant_log.size()) check_value("grant_order", grant_log[g0 + k], exp_order[k]);
    drain();

    // Single req0 job: e2e4, executor latency 3
    lat = 3;
    offer(1'b0, start_board(), mk(4, 1, 4, 3));
    drain();

    // Hung executor on a req1 job, then a stale executor result
    hang = 1'b1;
    offer(1'b1, start_board(), mk(4, 6, 4, 4));
    drain();
    hang = 1'b0;
    check_value("idle_after_err", busy, 0);
    np = n_pulse;
    inj_b = start_board();
    inj_v = 1'b1;
    tick();
    inj_v = 1'b0;
    repeat (5) tick();
    check_value("stale_quiet", n_pulse - np, 0);
    check_value("stale_state", busy, 0);

    // req1 held valid while a req0 job is in flight
    lat = 3;
    offer(1'b0, start_board(), mk(3, 1, 3, 3));
    gs = grant_log.size();
    r1b = start_board(); r1m = mk(2, 6, 2, 4); r1v = 1'b1;
    for (int t = 0; t < 20 && grant_log.size() == gs; t++) tick();
    r1v = 1'b0;
    check_value("held_accepted", grant_log.size() - gs, 1);
    check_value("held_accept_edge", acc_edge[1] - acc_edge[0], lat + 3);
    drain();

    // Reset while waiting on the executor
    lat = 6;
    offer(1'b0, start_board(), mk(6, 0, 5, 2));
    repeat (3) tick();
    rst = 1'b1;
    q.delete();
    np = n_pulse;
    tick();
    rst = 1'b0;
    check_value("busy_after_rst", busy, 0);
    repeat (8) tick();
    check_value("rst_quiet", n_pulse - np, 0);
    lat = 3;
    offer(1'b0, start_board(), mk(1, 0, 2, 2));
    drain();

    // Result arrives on the timeout threshold cycle (TIMEOUT_CYCLES=4, latency 3)
    t4_r0b = start_board(); t4_r0m = mk(3, 1, 3, 2); t4_r0v = 1'b1;
    for (int t = 0; t < 20 && t4_acc == 0; t++) tick();
    t4_r0v = 1'b0;
    repeat (10) tick();
    check_value("thr_valid_count", t4_res_n, 1);
    check_value("thr_latency", t4_res_cyc - t4_acc, 5);
    check_value("thr_board", t4_res_board, apply_move(start_board(), mk(3, 1, 3, 2)));
    check_value("thr_err_count", t4_err_n, 0);
    check_value("thr_idle", {t4_busy, t4_r1rdy}, 0);
    check_value("thr_req1_board", t4_r1bo, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
